routing_join_fsm: RTL and testbench

Per-node join controller that drives the `routing_state_t` sequence from `system_types`. It sits directly downstream of the system-flit decoder and upstream of the system-flit encoder. It consumes decoded system messages (header + 64-bit `system_payload_t`), issues parent/join requests, and acquires the node's parent ID and assigned child ID. It also handles re-attachment after separation.

---
 rtl/routing_join_fsm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_routing_join_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/routing_join_fsm.sv
// routing_join_fsm: per-node join controller. It finds a parent, acquires a child ID,
// and re-attaches after the link to the parent is lost.

package system_types;

  typedef enum logic [3:0] {
    INIT                      = 4'd0,
    I_GENERATE_PARENT_REQUEST = 4'd1,
    I_WAIT_PARENT_ACK         = 4'd2,
    I_GENERATE_JOIN_REQUEST   = 4'd3,
    I_WAIT_JOIN_ACK           = 4'd4,
    NORMAL                    = 4'd5,
    S_GENERATE_PARENT_REQUEST = 4'd6,
    S_WAIT_PARENT_ACK         = 4'd7,
    S_GENERATE_JOIN_REQUEST   = 4'd8,
    S_WAIT_JOIN_ACK           = 4'd9,
    FATAL_ERROR               = 4'd10
  } routing_state_t;

  typedef logic [7:0]  system_header_t;
  typedef logic [63:0] system_payload_t;

  localparam system_header_t S_NOPE           = 8'h00;
  localparam system_header_t S_RESET          = 8'h01;
  localparam system_header_t S_PARENT_REQUEST = 8'h10;
  localparam system_header_t S_PARENT_ACK     = 8'h11;
  localparam system_header_t S_JOIN_REQUEST   = 8'h12;
  localparam system_header_t S_JOIN_ACK       = 8'h13;

  typedef struct packed {
    logic        is_init;
    logic [62:0] undefined;
  } parent_request_t;

  typedef struct packed {
    logic        is_init;
    logic [7:0]  parent_id;
    logic [7:0]  child_id;
    logic [7:0]  global_id;
    logic [38:0] undefined;
  } parent_ack_t;

  typedef struct packed {
    logic        is_init;
    logic [7:0]  parent_id;
    logic [7:0]  child_id;
    logic [46:0] undefined;
  } join_request_t;

  typedef struct packed {
    logic        is_init;
    logic [7:0]  current_child_id;
    logic [7:0]  parent_id;
    logic [7:0]  child_id;
    logic [38:0] undefined;
  } join_ack_t;

endpackage

module routing_join_fsm
  import system_types::*;
#(
  parameter logic [7:0] HW_ID     = 8'h01,
  parameter int         TIMEOUT   = 256,
  parameter int         MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  system_header_t  rx_header,
  input  system_payload_t rx_payload,
  output logic            tx_valid,
  input  logic            tx_ready,
  output system_header_t  tx_header,
  output system_payload_t tx_payload,
  input  logic            separate,
  output routing_state_t  state,
  output logic [7:0]      node_id,
  output logic [7:0]      parent_id,
  output logic            joined,
  output logic            fatal
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [TW-1:0] TIMER_LOAD  = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  routing_state_t  state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [RW-1:0]   retry, retry_n;
  logic [7:0]      cand, cand_n;
  logic [7:0]      parent_n, node_n;
  logic            tx_valid_n, joined_n, fatal_n;
  system_header_t  tx_header_n;
  system_payload_t tx_payload_n;

  parent_ack_t     rx_pack;
  join_ack_t       rx_jack;
  parent_request_t preq;
  join_request_t   jreq;

  logic is_init_phase, reset_msg, pa_match, ja_match, expire, handshake;

  assign rx_ready = 1'b1;
  assign rx_pack  = rx_payload;
  assign rx_jack  = rx_payload;

  // Next-state logic: S_RESET first, then per-state match / timeout / handshake handling.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    retry_n  = retry;
    parent_n = parent_id;
    cand_n   = cand;
    node_n   = node_id;

    is_init_phase = (state == I_GENERATE_PARENT_REQUEST) || (state == I_WAIT_PARENT_ACK) ||
                    (state == I_GENERATE_JOIN_REQUEST)   || (state == I_WAIT_JOIN_ACK);
    reset_msg = rx_valid && (rx_header == S_RESET);
    pa_match  = rx_valid && (rx_header == S_PARENT_ACK) &&
                (rx_pack.is_init == is_init_phase) && (rx_pack.global_id == HW_ID);
    ja_match  = rx_valid && (rx_header == S_JOIN_ACK) &&
                (rx_jack.is_init == is_init_phase) &&
                (rx_jack.parent_id == parent_id) && (rx_jack.child_id == cand);
    expire    = (timer <= TW'(1));
    handshake = tx_valid && tx_ready;

    if (reset_msg) begin
      state_n  = INIT;
      timer_n  = '0;
      retry_n  = '0;
      parent_n = '0;
      cand_n   = '0;
      node_n   = '0;
    end else begin
      case (state)
        INIT: state_n = I_GENERATE_PARENT_REQUEST;

        I_GENERATE_PARENT_REQUEST, S_GENERATE_PARENT_REQUEST: begin
          if (handshake) begin
            state_n = is_init_phase ? I_WAIT_PARENT_ACK : S_WAIT_PARENT_ACK;
            timer_n = TIMER_LOAD;
          end
        end

        I_GENERATE_JOIN_REQUEST, S_GENERATE_JOIN_REQUEST: begin
          if (handshake) begin
            state_n = is_init_phase ? I_WAIT_JOIN_ACK : S_WAIT_JOIN_ACK;
            timer_n = TIMER_LOAD;
          end
        end

        I_WAIT_PARENT_ACK, S_WAIT_PARENT_ACK: begin
          if (pa_match) begin
            parent_n = rx_pack.parent_id;
            cand_n   = rx_pack.child_id;
            retry_n  = '0;
            timer_n  = '0;
            state_n  = is_init_phase ? I_GENERATE_JOIN_REQUEST : S_GENERATE_JOIN_REQUEST;
          end else if (expire) begin
            timer_n = '0;
            if (retry < RETRY_LIMIT) begin
              retry_n = retry + RW'(1);
              state_n = is_init_phase ? I_GENERATE_PARENT_REQUEST : S_GENERATE_PARENT_REQUEST;
            end else begin
              state_n = FATAL_ERROR;
            end
          end else begin
            timer_n = timer - TW'(1);
          end
        end

        I_WAIT_JOIN_ACK, S_WAIT_JOIN_ACK: begin
          if (ja_match) begin
            node_n  = cand;
            retry_n = '0;
            timer_n = '0;
            state_n = NORMAL;
          end else if (expire) begin
            timer_n = '0;
            if (retry < RETRY_LIMIT) begin
              retry_n = retry + RW'(1);
              state_n = is_init_phase ? I_GENERATE_JOIN_REQUEST : S_GENERATE_JOIN_REQUEST;
            end else begin
              state_n = FATAL_ERROR;
            end
          end else begin
            timer_n = timer - TW'(1);
          end
        end

        NORMAL: begin
          if (separate) begin
            state_n = S_GENERATE_PARENT_REQUEST;
            retry_n = '0;
          end
        end

        FATAL_ERROR: state_n = FATAL_ERROR;

        default: state_n = INIT;
      endcase
    end
  end

  // Output decode from the upcoming state so that registered outputs line up with the state.
  always_comb begin
    preq         = '0;
    jreq         = '0;
    tx_valid_n   = 1'b0;
    tx_header_n  = S_NOPE;
    tx_payload_n = '0;
    joined_n     = (state_n == NORMAL);
    fatal_n      = (state_n == FATAL_ERROR);
    case (state_n)
      I_GENERATE_PARENT_REQUEST, S_GENERATE_PARENT_REQUEST: begin
        preq.is_init = (state_n == I_GENERATE_PARENT_REQUEST);
        tx_valid_n   = 1'b1;
        tx_header_n  = S_PARENT_REQUEST;
        tx_payload_n = preq;
      end
      I_GENERATE_JOIN_REQUEST, S_GENERATE_JOIN_REQUEST: begin
        jreq.is_init   = (state_n == I_GENERATE_JOIN_REQUEST);
        jreq.parent_id = parent_n;
        jreq.child_id  = cand_n;
        tx_valid_n     = 1'b1;
        tx_header_n    = S_JOIN_REQUEST;
        tx_payload_n   = jreq;
      end
      default: ;
    endcase
  end

  // State, bookkeeping and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      timer      <= '0;
      retry      <= '0;
      cand       <= '0;
      parent_id  <= '0;
      node_id    <= '0;
      tx_valid   <= 1'b0;
      tx_header  <= S_NOPE;
      tx_payload <= '0;
      joined     <= 1'b0;
      fatal      <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      retry      <= retry_n;
      cand       <= cand_n;
      parent_id  <= parent_n;
      node_id    <= node_n;
      tx_valid   <= tx_valid_n;
      tx_header  <= tx_header_n;
      tx_payload <= tx_payload_n;
      joined     <= joined_n;
      fatal      <= fatal_n;
    end
  end

endmodule

// File: tb/tb_routing_join_fsm.sv
// tb_routing_join_fsm: directed self-checking bench for routing_join_fsm
// (HW_ID=8'h2A, TIMEOUT=16, MAX_RETRY=2).

module tb_routing_join_fsm;
  import system_types::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  system_header_t  rx_header = S_NOPE;
  system_payload_t rx_payload = '0;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  system_header_t  tx_header;
  system_payload_t tx_payload;
  logic            separate = 1'b0;
  routing_state_t  state;
  logic [7:0]      node_id;
  logic [7:0]      parent_id;
  logic            joined;
  logic            fatal;

  int total = 0;
  int bad   = 0;

  routing_join_fsm #(.HW_ID(8'h2A), .TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_header(rx_header), .rx_payload(rx_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_header(tx_header), .tx_payload(tx_payload),
    .separate(separate), .state(state), .node_id(node_id), .parent_id(parent_id),
    .joined(joined), .fatal(fatal)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input system_header_t hdr, input system_payload_t pay);
    rx_valid   = 1'b1;
    rx_header  = hdr;
    rx_payload = pay;
    tick(1);
    rx_valid   = 1'b0;
    rx_header  = S_NOPE;
    rx_payload = '0;
  endtask

  task automatic pulse_separate();
    separate = 1'b1;
    tick(1);
    separate = 1'b0;
  endtask

  function automatic logic [63:0] pa_pay(input logic i, input logic [7:0] p, input logic [7:0] c,
                                         input logic [7:0] g);
    return {i, p, c, g, 39'd0};
  endfunction

  function automatic logic [63:0] ja_pay(input logic i, input logic [7:0] cur, input logic [7:0] p,
                                         input logic [7:0] c);
    return {i, cur, p, c, 39'd0};
  endfunction

  function automatic logic [63:0] preq_pay(input logic i);
    return {i, 63'd0};
  endfunction

  function automatic logic [63:0] jreq_pay(input logic i, input logic [7:0] p, input logic [7:0] c);
    return {i, p, c, 47'd0};
  endfunction

  // Directed sequence of scenarios.
  initial begin
    #2 rst = 1'b1;
    tick(1);
    check("rst_state",   64'(state), 64'(INIT));
    check("rst_txvalid", 64'(tx_valid), 64'd0);
    check("rst_header",  64'(tx_header), 64'(S_NOPE));
    check("rst_payload", tx_payload, 64'd0);
    check("rst_ids",     64'({node_id, parent_id}), 64'd0);
    check("rst_flags",   64'({joined, fatal}), 64'd0);
    check("rx_ready",    64'(rx_ready), 64'd1);
    rst = 1'b0;

    // Clean init
    tick(1);
    check("init_gpr_state",  64'(state), 64'(I_GENERATE_PARENT_REQUEST));
    check("init_gpr_valid",  64'(tx_valid), 64'd1);
    check("init_gpr_header", 64'(tx_header), 64'(S_PARENT_REQUEST));
    check("init_gpr_pay",    tx_payload, preq_pay(1'b1));
    tick(1);
    check("init_wpa_state",  64'(state), 64'(I_WAIT_PARENT_ACK));
    check("init_wpa_valid",  64'(tx_valid), 64'd0);
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h05, 8'h11, 8'h2A));
    check("init_gjr_state",  64'(state), 64'(I_GENERATE_JOIN_REQUEST));
    check("init_gjr_header", 64'(tx_header), 64'(S_JOIN_REQUEST));
    check("init_gjr_bits",   64'(tx_payload[63:47]), 64'({1'b1, 8'h05, 8'h11}));
    check("init_gjr_pay",    tx_payload, jreq_pay(1'b1, 8'h05, 8'h11));
    tick(1);
    check("init_wja_state",  64'(state), 64'(I_WAIT_JOIN_ACK));
    send(S_JOIN_ACK, ja_pay(1'b1, 8'h12, 8'h05, 8'h11));
    check("init_normal",     64'(state), 64'(NORMAL));
    check("init_node",       64'(node_id), 64'h11);
    check("init_parent",     64'(parent_id), 64'h05);
    check("init_joined",     64'(joined), 64'd1);
    check("init_txidle",     64'(tx_valid), 64'd0);

    // Stray ack in NORMAL is dropped
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h09, 8'h33, 8'h2A));
    check("normal_ignore",   64'(state), 64'(NORMAL));
    check("normal_parent",   64'(parent_id), 64'h05);

    // Separation and re-attachment
    pulse_separate();
    check("sep_state",  64'(state), 64'(S_GENERATE_PARENT_REQUEST));
    check("sep_valid",  64'(tx_valid), 64'd1);
    check("sep_pay",    tx_payload, preq_pay(1'b0));
    check("sep_joined", 64'(joined), 64'd0);
    check("sep_node",   64'(node_id), 64'h11);
    tick(1);
    check("sep_wpa",    64'(state), 64'(S_WAIT_PARENT_ACK));
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h07, 8'h22, 8'h2A));
    check("sep_initack_ignored", 64'(state), 64'(S_WAIT_PARENT_ACK));
    send(S_PARENT_ACK, pa_pay(1'b0, 8'h07, 8'h22, 8'h2A));
    check("sep_gjr",     64'(state), 64'(S_GENERATE_JOIN_REQUEST));
    check("sep_gjr_pay", tx_payload, jreq_pay(1'b0, 8'h07, 8'h22));
    tick(1);
    check("sep_wja",     64'(state), 64'(S_WAIT_JOIN_ACK));
    send(S_JOIN_ACK, ja_pay(1'b0, 8'h11, 8'h07, 8'h22));
    check("sep_normal",  64'(state), 64'(NORMAL));
    check("sep_newnode", 64'(node_id), 64'h22);
    check("sep_newpar",  64'(parent_id), 64'h07);
    check("sep_rejoin",  64'(joined), 64'd1);

    // S_RESET from NORMAL, then backpressure
    send(S_RESET, 64'd0);
    check("sreset_state", 64'(state), 64'(INIT));
    check("sreset_ids",   64'({node_id, parent_id}), 64'd0);
    tx_ready = 1'b0;
    tick(1);
    check("bp_gpr", 64'(state), 64'(I_GENERATE_PARENT_REQUEST));
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("bp_valid",  64'(tx_valid), 64'd1);
      check("bp_header", 64'(tx_header), 64'(S_PARENT_REQUEST));
      check("bp_pay",    tx_payload, preq_pay(1'b1));
    end
    tx_ready = 1'b1;
    tick(1);
    check("bp_wpa", 64'(state), 64'(I_WAIT_PARENT_ACK));

    // Mismatch filter: wrong global_id and an out-of-phase JOIN_ACK
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h05, 8'h11, 8'h2B));
    check("mm_global", 64'(state), 64'(I_WAIT_PARENT_ACK));
    send(S_JOIN_ACK, ja_pay(1'b1, 8'h00, 8'h00, 8'h00));
    check("mm_joinack", 64'(state), 64'(I_WAIT_PARENT_ACK));
    tick(13);
    check("mm_wait16", 64'(state), 64'(I_WAIT_PARENT_ACK));
    tick(1);
    check("mm_retry1", 64'(state), 64'(I_GENERATE_PARENT_REQUEST));

    // Retries exhaust into FATAL_ERROR
    tick(1);
    check("rf_wpa2", 64'(state), 64'(I_WAIT_PARENT_ACK));
    tick(15);
    check("rf_wpa2_end", 64'(state), 64'(I_WAIT_PARENT_ACK));
    tick(1);
    check("rf_retry2", 64'(state), 64'(I_GENERATE_PARENT_REQUEST));
    check("rf_retry2_valid", 64'(tx_valid), 64'd1);
    tick(1);
    tick(15);
    check("rf_wpa3_end", 64'(state), 64'(I_WAIT_PARENT_ACK));
    tick(1);
    check("rf_fatal_state", 64'(state), 64'(FATAL_ERROR));
    check("rf_fatal_flag",  64'(fatal), 64'd1);
    check("rf_fatal_txv",   64'(tx_valid), 64'd0);
    pulse_separate();
    tick(2);
    check("rf_sticky", 64'(state), 64'(FATAL_ERROR));
    send(S_RESET, 64'd0);
    check("rf_reset_state", 64'(state), 64'(INIT));
    check("rf_reset_fatal", 64'(fatal), 64'd0);
    tick(1);
    check("rf_newreq", 64'(tx_valid), 64'd1);
    check("rf_newreq_pay", tx_payload, preq_pay(1'b1));

    // Boundary: match on the 16th WAIT cycle wins over timeout
    tick(1);
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h05, 8'h11, 8'h2A));
    check("bd_gjr", 64'(state), 64'(I_GENERATE_JOIN_REQUEST));
    tick(1);
    check("bd_wja_first", 64'(state), 64'(I_WAIT_JOIN_ACK));
    tick(15);
    check("bd_wja_last", 64'(state), 64'(I_WAIT_JOIN_ACK));
    send(S_JOIN_ACK, ja_pay(1'b1, 8'h12, 8'h05, 8'h11));
    check("bd_normal", 64'(state), 64'(NORMAL));
    check("bd_node",   64'(node_id), 64'h11);

    // rst mid-operation
    send(S_RESET, 64'd0);
    tick(2);
    send(S_PARENT_ACK, pa_pay(1'b1, 8'h05, 8'h11, 8'h2A));
    tick(1);
    check("mr_wja", 64'(state), 64'(I_WAIT_JOIN_ACK));
    check("mr_par", 64'(parent_id), 64'h05);
    rst = 1'b1;
    #1;
    check("mr_state",   64'(state), 64'(INIT));
    check("mr_txv",     64'(tx_valid), 64'd0);
    check("mr_header",  64'(tx_header), 64'(S_NOPE));
    check("mr_payload", tx_payload, 64'd0);
    check("mr_ids",     64'({node_id, parent_id}), 64'd0);
    check("mr_flags",   64'({joined, fatal}), 64'd0);
    tick(1);
    rst = 1'b0;
    tx_ready = 1'b0;
    check("mr_init", 64'(state), 64'(INIT));
    tick(1);
    check("mr_gpr", 64'(state), 64'(I_GENERATE_PARENT_REQUEST));

    // S_RESET mid-request drops tx_valid on the next cycle
    send(S_RESET, 64'd0);
    check("srq_state", 64'(state), 64'(INIT));
    check("srq_txv",   64'(tx_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
